floor_req_scheduler: RTL and testbench

FLOOR_REQ_SCHEDULER -- requirements
Module: floor_req_scheduler

---
 rtl/elevator_pkg.sv | 64 ++++++
 rtl/btn_debounce.sv | 83 ++++++++
 rtl/floor_req_scheduler.sv | 173 +++++++++++++++++
 tb/tb_floor_req_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator subsystem: floor count, floor index
// width, the scheduler state enum and small helpers for one-hot encoding and
// the SCAN target search. Imported by floor_req_scheduler and shared with the
// elevator controller.
// ---------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef logic [NUM_FLOORS-1:0] floor_mask_t;
    typedef logic [FLOOR_W-1:0]    floor_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DOOR  = 2'd2,
        EMERG = 2'd3
    } sched_state_t;

    // Result of a directional search: whether a floor was found, and which.
    typedef struct packed {
        logic       found;
        floor_idx_t floor;
    } floor_pick_t;

    function automatic floor_mask_t floor_onehot(input floor_idx_t f);
        floor_mask_t m;
        m    = '0;
        m[f] = 1'b1;
        return m;
    endfunction

    // Nearest pending floor strictly above cur. Scanning from the top down
    // lets the last hit be the lowest qualifying floor.
    function automatic floor_pick_t scan_up(input floor_mask_t pend, input floor_idx_t cur);
        floor_pick_t pick;
        pick = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pend[i] && (i > int'(cur))) begin
                pick.found = 1'b1;
                pick.floor = floor_idx_t'(i);
            end
        end
        return pick;
    endfunction

    // Nearest pending floor strictly below cur. Scanning from the bottom up
    // lets the last hit be the highest qualifying floor.
    function automatic floor_pick_t scan_down(input floor_mask_t pend, input floor_idx_t cur);
        floor_pick_t pick;
        pick = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i < int'(cur))) begin
                pick.found = 1'b1;
                pick.floor = floor_idx_t'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One call-button input conditioner: 2-flop synchronizer, optional
// consecutive-high filter, and rising-edge detection. press_o pulses for one
// cycle when a press is accepted.
//
// Configuration macro: FLOOR_REQ_DEBOUNCE_EN
//   defined   - a press is accepted on the DEBOUNCE_CYCLES-th consecutive
//               synchronized-high cycle
//   undefined - a press is accepted on the synchronized rising edge and
//               DEBOUNCE_CYCLES has no effect
//
// Ports
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   btnRaw_i in  raw asynchronous button level
//   press_o  out one-cycle accepted-press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage synchronizer; nothing downstream looks at btnRaw_i directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btnRaw_i;
            sync2_q <= sync1_q;
        end
    end

    // A filter length below one is not a meaningful setting; this empty
    // block marks such a build in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    end

`ifdef FLOOR_REQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] highCnt_q;

    // Counts consecutive synchronized-high cycles and saturates, so one long
    // press produces exactly one accepted pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            highCnt_q <= '0;
        end else if (!sync2_q) begin
            highCnt_q <= '0;
        end else if (highCnt_q != CNT_FULL) begin
            highCnt_q <= highCnt_q + 1'b1;
        end
    end

    // Fires on the cycle the level has been high DEBOUNCE_CYCLES times in a row.
    assign press_o = sync2_q && (highCnt_q == CNT_LAST);
`else
    logic level_q;

    // Previous synchronized level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= sync2_q;
        end
    end

    assign press_o = sync2_q & ~level_q;
`endif

endmodule

// File: rtl/floor_req_scheduler.sv
// ---------------------------------------------------------------------------
// floor_req_scheduler
// Latches call-button presses and hands one target floor at a time to the
// elevator controller using a SCAN policy, then holds the door open for a
// fixed time on arrival. An emergency stop freezes targeting but keeps
// collecting presses.
//
// Configuration macro: FLOOR_REQ_DEBOUNCE_EN (see btn_debounce).
//
// Ports
//   clk            in  clock, rising edge
//   reset          in  asynchronous active-high reset
//   btn[3:0]       in  raw call buttons, bit f = floor f
//   current_floor  in  floor reported by the elevator controller
//   motor_stop     in  elevator is stopped
//   emergency_stop in  emergency stop
//   floor_req[3:0] out one-hot target floor, 0 = none
//   pending[3:0]   out latched unserved requests
//   dir_up         out scan direction, 1 = up
//   door_open      out door-open command
// ---------------------------------------------------------------------------
module floor_req_scheduler
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOOR_CYCLES     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  motor_stop,
    input  logic                  emergency_stop,
    output logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open
);

    localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    floor_mask_t       press;
    floor_mask_t       clearMask;

    sched_state_t      state_q,     state_d;
    floor_mask_t       pending_q,   pending_d;
    floor_mask_t       floorReq_q,  floorReq_d;
    logic              dirUp_q,     dirUp_d;
    logic              doorOpen_q,  doorOpen_d;
    logic [DOOR_W-1:0] doorCnt_q,   doorCnt_d;
    floor_idx_t        target_q,    target_d;

    floor_pick_t       upPick;
    floor_pick_t       downPick;
    floor_pick_t       ahead;
    floor_pick_t       behind;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk     (clk),
            .reset   (reset),
            .btnRaw_i(btn[f]),
            .press_o (press[f])
        );
    end

    // Next-state logic. Emergency overrides every state. Pending is the only
    // register touched in every state: presses always latch, and a clear in
    // the same cycle wins over a fresh press on that floor.
    always_comb begin
        state_d    = state_q;
        floorReq_d = floorReq_q;
        dirUp_d    = dirUp_q;
        doorOpen_d = doorOpen_q;
        doorCnt_d  = doorCnt_q;
        target_d   = target_q;
        clearMask  = '0;

        upPick   = scan_up(pending_q, current_floor);
        downPick = scan_down(pending_q, current_floor);
        ahead    = dirUp_q ? upPick : downPick;
        behind   = dirUp_q ? downPick : upPick;

        if (emergency_stop) begin
            state_d    = EMERG;
            floorReq_d = '0;
            doorOpen_d = 1'b0;
            doorCnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q[current_floor] && motor_stop) begin
                        clearMask  = floor_onehot(current_floor);
                        floorReq_d = '0;
                        doorOpen_d = 1'b1;
                        doorCnt_d  = '0;
                        state_d    = DOOR;
                    end else if (pending_q != '0) begin
                        // With nothing strictly ahead or behind, the only
                        // request is the current floor while still moving:
                        // target it directly and keep the direction.
                        if (ahead.found) begin
                            target_d = ahead.floor;
                        end else if (behind.found) begin
                            target_d = behind.floor;
                            dirUp_d  = ~dirUp_q;
                        end else begin
                            target_d = current_floor;
                        end
                        floorReq_d = floor_onehot(target_d);
                        state_d    = SERVE;
                    end
                end
                SERVE: begin
                    if ((current_floor == target_q) && motor_stop) begin
                        clearMask  = floor_onehot(target_q);
                        floorReq_d = '0;
                        doorOpen_d = 1'b1;
                        doorCnt_d  = '0;
                        state_d    = DOOR;
                    end
                end
                DOOR: begin
                    if (doorCnt_q == DOOR_LAST) begin
                        doorOpen_d = 1'b0;
                        doorCnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        doorCnt_d = doorCnt_q + 1'b1;
                    end
                end
                EMERG: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        pending_d = (pending_q | press) & ~clearMask;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            floorReq_q <= '0;
            dirUp_q    <= 1'b1;
            doorOpen_q <= 1'b0;
            doorCnt_q  <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            floorReq_q <= floorReq_d;
            dirUp_q    <= dirUp_d;
            doorOpen_q <= doorOpen_d;
            doorCnt_q  <= doorCnt_d;
            target_q   <= target_d;
        end
    end

    assign floor_req = floorReq_q;
    assign pending   = pending_q;
    assign dir_up    = dirUp_q;
    assign door_open = doorOpen_q;

endmodule

// File: tb/tb_floor_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_floor_req_scheduler
// Self-checking bench for floor_req_scheduler: table of SCAN selection cases,
// hand-written multi-cycle sequences, and a randomized run compared against a
// behavioural model. Honours FLOOR_REQ_DEBOUNCE_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_floor_req_scheduler;

    localparam int DEB   = 4;
    localparam int DOORC = 3;
    localparam int HOLD  = DEB + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = '0;
    logic [1:0] current_floor = '0;
    logic       motor_stop = 1'b0;
    logic       emergency_stop = 1'b0;
    logic [3:0] floor_req;
    logic [3:0] pending;
    logic       dir_up;
    logic       door_open;

    int assertCount = 0;
    int failCount   = 0;

    floor_req_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .DOOR_CYCLES    (DOORC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .current_floor (current_floor),
        .motor_stop    (motor_stop),
        .emergency_stop(emergency_stop),
        .floor_req     (floor_req),
        .pending       (pending),
        .dir_up        (dir_up),
        .door_open     (door_open)
    );

    always #5 clk = ~clk;

    // Behavioural reference: button history as plain delayed samples and
    // run lengths, requests as a bit set, the door as a countdown.
    typedef enum int {M_IDLE, M_SERVE, M_DOOR, M_EMERG} mode_t;
    mode_t      mMode;
    logic [3:0] mPend;
    int         mTarget;
    bit         mDirUp;
    int         mDoorLeft;
    logic [3:0] mDly1;
    logic [3:0] mDly2;
    int         mRun [4];

    function automatic int modelPick(input logic [3:0] pend, input int cf, input bit up, output bit flip);
        flip = 1'b0;
        for (int d = 1; d < 4; d++) begin
            int f = up ? cf + d : cf - d;
            if (f >= 0 && f < 4 && pend[f]) return f;
        end
        flip = 1'b1;
        for (int d = 1; d < 4; d++) begin
            int f = up ? cf - d : cf + d;
            if (f >= 0 && f < 4 && pend[f]) return f;
        end
        flip = 1'b0;
        return cf;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [3:0] mPress;
        logic [3:0] clr;
        bit         flip;
        int         cf;
        if (reset) begin
            mMode     = M_IDLE;
            mPend     = '0;
            mTarget   = 0;
            mDirUp    = 1'b1;
            mDoorLeft = 0;
            mDly1     = '0;
            mDly2     = '0;
            for (int f = 0; f < 4; f++) mRun[f] = 0;
        end else begin
            mPress = '0;
            for (int f = 0; f < 4; f++) begin
                int runNow;
                runNow = mDly2[f] ? mRun[f] + 1 : 0;
`ifdef FLOOR_REQ_DEBOUNCE_EN
                mPress[f] = (runNow == DEB);
`else
                mPress[f] = mDly2[f] && (mRun[f] == 0);
`endif
                mRun[f] = (runNow > 1000) ? 1000 : runNow;
            end
            mDly2 = mDly1;
            mDly1 = btn;

            clr = '0;
            cf  = int'(current_floor);
            if (emergency_stop) begin
                mMode = M_EMERG;
            end else begin
                case (mMode)
                    M_IDLE: begin
                        if (mPend[cf] && motor_stop) begin
                            clr[cf]   = 1'b1;
                            mMode     = M_DOOR;
                            mDoorLeft = DOORC;
                        end else if (mPend != 0) begin
                            mTarget = modelPick(mPend, cf, mDirUp, flip);
                            if (flip) mDirUp = !mDirUp;
                            mMode = M_SERVE;
                        end
                    end
                    M_SERVE: begin
                        if (cf == mTarget && motor_stop) begin
                            clr[mTarget] = 1'b1;
                            mMode        = M_DOOR;
                            mDoorLeft    = DOORC;
                        end
                    end
                    M_DOOR: begin
                        mDoorLeft--;
                        if (mDoorLeft == 0) mMode = M_IDLE;
                    end
                    default: mMode = M_IDLE;
                endcase
            end
            mPend = (mPend | mPress) & ~clr;
        end
    end

    function automatic logic [9:0] modelOutputs();
        logic [3:0] req;
        req = '0;
        if (mMode == M_SERVE) req[mTarget] = 1'b1;
        return {req, mPend, mDirUp, (mMode == M_DOOR)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic [1:0] cf, input logic ms, input logic es);
        btn            = b;
        current_floor  = cf;
        motor_stop     = ms;
        emergency_stop = es;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 2'd0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pressButtons(input logic [3:0] mask);
        btn = mask;
        tick(HOLD);
        btn = 4'b0000;
    endtask

    // Bounded wait for a target to appear; running out counts as a failure.
    task automatic waitFloorReq(input string name);
        int n;
        n = 0;
        while (floor_req == 4'b0000 && n < 30) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_arrive"}, 16'(floor_req != 4'b0000), 16'd1);
    endtask

    typedef struct {
        logic [1:0] startFloor;
        logic [3:0] pressMask;
        logic [3:0] expReq;
        logic       expDirUp;
    } scan_vec_t;

    scan_vec_t vecs [8];

    initial begin
        int doorHigh;
        bit sawDoor;
        bit lateBit;
        bit reqSeen;

        vecs[0] = '{2'd0, 4'b1000, 4'b1000, 1'b1};
        vecs[1] = '{2'd0, 4'b0110, 4'b0010, 1'b1};
        vecs[2] = '{2'd2, 4'b0011, 4'b0010, 1'b0};
        vecs[3] = '{2'd1, 4'b1101, 4'b0100, 1'b1};
        vecs[4] = '{2'd3, 4'b0101, 4'b0100, 1'b0};
        vecs[5] = '{2'd3, 4'b0001, 4'b0001, 1'b0};
        vecs[6] = '{2'd1, 4'b0001, 4'b0001, 1'b0};
        vecs[7] = '{2'd2, 4'b1010, 4'b1000, 1'b1};

        // Reset state and a single press to floor 3 served end to end.
        doReset();
        checkOutput("rst_floor_req", 16'(floor_req), 16'h0);
        checkOutput("rst_pending",   16'(pending),   16'h0);
        checkOutput("rst_dir_up",    16'(dir_up),    16'h1);
        checkOutput("rst_door_open", 16'(door_open), 16'h0);

        applyStimulus(4'b1000, 2'd0, 1'b1, 1'b0);
        tick(8);
        btn = 4'b0000;
        tick(2);
        checkOutput("f3_pending",   16'(pending),   16'h8);
        checkOutput("f3_floor_req", 16'(floor_req), 16'h8);
        checkOutput("f3_dir_up",    16'(dir_up),    16'h1);
        applyStimulus(4'b0000, 2'd3, 1'b1, 1'b0);
        tick(1);
        checkOutput("f3_arrive_pending", 16'(pending),   16'h0);
        checkOutput("f3_arrive_req",     16'(floor_req), 16'h0);
        doorHigh = 0;
        for (int i = 0; i < 10; i++) begin
            if (door_open) doorHigh++;
            tick(1);
        end
        checkOutput("f3_door_cycles", 16'(doorHigh), 16'(DOORC));

        // Short press: filtered out with the debounce filter, latched without it.
        doReset();
        applyStimulus(4'b0010, 2'd0, 1'b0, 1'b0);
        tick(2);
        btn = 4'b0000;
        tick(6);
`ifdef FLOOR_REQ_DEBOUNCE_EN
        checkOutput("short_press_pending", 16'(pending), 16'h0);
`else
        checkOutput("short_press_pending", 16'(pending), 16'h2);
`endif

        // SCAN selection table: every case starts from reset (dir_up = 1).
        for (int v = 0; v < 8; v++) begin
            doReset();
            applyStimulus(4'b0000, vecs[v].startFloor, 1'b0, 1'b0);
            pressButtons(vecs[v].pressMask);
            waitFloorReq($sformatf("scan%0d", v));
            checkOutput($sformatf("scan%0d_req", v),     16'(floor_req), 16'(vecs[v].expReq));
            checkOutput($sformatf("scan%0d_dir", v),     16'(dir_up),    16'(vecs[v].expDirUp));
            checkOutput($sformatf("scan%0d_pending", v), 16'(pending),   16'(vecs[v].pressMask));
        end

        // Reversal at floor 2, then continue downward after serving floor 1.
        doReset();
        applyStimulus(4'b0000, 2'd2, 1'b0, 1'b0);
        pressButtons(4'b0011);
        waitFloorReq("rev");
        checkOutput("rev_req", 16'(floor_req), 16'h2);
        checkOutput("rev_dir", 16'(dir_up),    16'h0);
        applyStimulus(4'b0000, 2'd1, 1'b1, 1'b0);
        tick(1);
        checkOutput("rev_serve_pending", 16'(pending),   16'h1);
        checkOutput("rev_serve_door",    16'(door_open), 16'h1);
        tick(DOORC);
        waitFloorReq("rev_next");
        checkOutput("rev_next_req", 16'(floor_req), 16'h1);
        checkOutput("rev_next_dir", 16'(dir_up),    16'h0);

        // Emergency stop while heading for floor 3.
        doReset();
        pressButtons(4'b1000);
        waitFloorReq("emg");
        emergency_stop = 1'b1;
        tick(1);
        checkOutput("emg_req",  16'(floor_req), 16'h0);
        checkOutput("emg_door", 16'(door_open), 16'h0);
        tick(1);
        checkOutput("emg_pending", 16'(pending), 16'h8);
        emergency_stop = 1'b0;
        waitFloorReq("emg_release");
        checkOutput("emg_release_req", 16'(floor_req), 16'h8);
        emergency_stop = 1'b1;
        pressButtons(4'b0010);
        tick(2);
        checkOutput("emg_press_pending", 16'(pending),   16'h a);
        checkOutput("emg_press_req",     16'(floor_req), 16'h0);
        emergency_stop = 1'b0;
        tick(1);
        waitFloorReq("emg_reselect");
        checkOutput("emg_reselect_req", 16'(floor_req), 16'h2);

        // Press on the floor the car is already stopped at.
        doReset();
        applyStimulus(4'b0010, 2'd1, 1'b1, 1'b0);
        sawDoor = 1'b0;
        lateBit = 1'b0;
        reqSeen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == HOLD) btn = 4'b0000;
            if (door_open) sawDoor = 1'b1;
            if (sawDoor && pending[1]) lateBit = 1'b1;
            if (floor_req != 4'b0000) reqSeen = 1'b1;
        end
        checkOutput("here_door_seen",   16'(sawDoor),   16'h1);
        checkOutput("here_pending_late", 16'(lateBit),  16'h0);
        checkOutput("here_req_seen",    16'(reqSeen),   16'h0);
        checkOutput("here_door_closed", 16'(door_open), 16'h0);

        // New presses during SERVE do not retarget; reset mid-DOOR wipes all.
        doReset();
        pressButtons(4'b1000);
        waitFloorReq("mid");
        pressButtons(4'b0101);
        tick(2);
        checkOutput("mid_no_retarget", 16'(floor_req), 16'h8);
        checkOutput("mid_pending",     16'(pending),   16'hd);
        applyStimulus(4'b0000, 2'd3, 1'b1, 1'b0);
        tick(1);
        checkOutput("mid_door",         16'(door_open), 16'h1);
        checkOutput("mid_door_pending", 16'(pending),   16'h5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_outputs", 16'({floor_req, pending, door_open}), 16'h0);
        checkOutput("async_rst_dir",     16'(dir_up), 16'h1);
        tick(1);
        reset = 1'b0;
        applyStimulus(4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);

        // Randomized run against the behavioural model.
        doReset();
        for (int c = 0; c < 500; c++) begin
            checkOutput("random", 16'({floor_req, pending, dir_up, door_open}), 16'(modelOutputs()));
            if ($urandom_range(5) == 0) btn = btn ^ (4'b0001 << $urandom_range(3));
            if ($urandom_range(7) == 0) current_floor = 2'($urandom_range(3));
            motor_stop = 1'($urandom_range(1));
            if (emergency_stop) emergency_stop = ($urandom_range(3) != 0);
            else                emergency_stop = ($urandom_range(39) == 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
